// File: rtl/dmem_lsu.sv
// dmem_lsu: byte-addressable RV32I data memory with valid/ready request port,
// configurable wait states and a registered one-cycle response strobe.
module dmem_lsu #(
  parameter int          DEPTH_WORDS  = 128,
  parameter int          WAIT_STATES  = 0,
  parameter logic [31:0] INIT_PATTERN = 32'hAAAAAAAA
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [2:0]  req_size_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, err_q;
  logic [2:0]  size_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [31:0] mem_q [DEPTH_WORDS] = '{default: INIT_PATTERN};
  logic        accept, commit, a_we, err, size_bad, misaligned, out_of_range;
  logic [2:0]  a_size;
  logic [31:0] a_addr, a_wdata, word, ext, wlane;
  logic [AW-1:0] idx;
  logic [3:0]  mask;
  logic [7:0]  b;
  logic [15:0] h;
  assign req_ready_o = rst_n && state_q == IDLE;
  assign rsp_valid_o = state_q == RESP;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign accept      = req_valid_i && req_ready_o;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = WAIT_STATES > 0 ? WAIT : RESP;
        cnt_d   = WAIT_STATES > 0 ? 4'(WAIT_STATES - 1) : 4'd0;
      end
      WAIT: begin
        state_d = cnt_q == 4'd0 ? RESP : WAIT;
        cnt_d   = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  // With zero wait states the access happens on the accepting edge, so use the live request.
  assign commit  = state_d == RESP && state_q != RESP;
  assign a_we    = state_q == IDLE ? req_we_i    : we_q;
  assign a_addr  = state_q == IDLE ? req_addr_i  : addr_q;
  assign a_size  = state_q == IDLE ? req_size_i  : size_q;
  assign a_wdata = state_q == IDLE ? req_wdata_i : wdata_q;
  assign size_bad     = a_size[1:0] == 2'b11 || (a_size[2] && (a_we || a_size[1]));
  assign misaligned   = (a_size[1:0] == 2'b01 && a_addr[0]) || (a_size[1:0] == 2'b10 && a_addr[1:0] != 2'b00);
  assign out_of_range = {2'b00, a_addr[31:2]} >= 32'(DEPTH_WORDS);
  assign err   = size_bad || misaligned || out_of_range;
  assign idx   = a_addr[AW+1:2];
  assign word  = mem_q[idx];
  assign b     = word[{a_addr[1:0], 3'b000} +: 8];
  assign h     = word[{a_addr[1], 4'b0000} +: 16];
  assign ext   = a_size[1] ? word : a_size[0] ? {{16{h[15] & ~a_size[2]}}, h} : {{24{b[7] & ~a_size[2]}}, b};
  assign wlane = a_size[1] ? a_wdata : a_size[0] ? {2{a_wdata[15:0]}} : {4{a_wdata[7:0]}};
  assign mask  = a_size[1] ? 4'b1111 : a_size[0] ? 4'b0011 << {a_addr[1], 1'b0} : 4'b0001 << a_addr[1:0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= req_we_i;
        addr_q  <= req_addr_i;
        size_q  <= req_size_i;
        wdata_q <= req_wdata_i;
      end
      if (commit) begin
        rdata_q <= a_we || err ? 32'd0 : ext;
        err_q   <= err;
      end
    end
  end
  // The array has no reset: contents survive rst_n, and commit is never true while in reset.
  always_ff @(posedge clk) begin
    if (commit && a_we && !err)
      for (int i = 0; i < 4; i++)
        if (mask[i]) mem_q[idx][8*i +: 8] <= wlane[8*i +: 8];
  end
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: scoreboard bench for dmem_lsu with one zero-wait and one three-wait instance.
module tb_dmem_lsu;
  logic        clk = 0;
  logic        rst0, rst3, v0, v3, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_size;
  logic        rdy0, rv0, er0, rdy3, rv3, er3;
  logic [31:0] rd0, rd3;
  logic [32:0] exp_q[$];
  int          n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  dmem_lsu #(.DEPTH_WORDS(128), .WAIT_STATES(0)) u0 (
    .clk(clk), .rst_n(rst0), .req_valid_i(v0), .req_ready_o(rdy0), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_size_i(req_size), .req_wdata_i(req_wdata),
    .rsp_valid_o(rv0), .rsp_rdata_o(rd0), .rsp_err_o(er0));

  dmem_lsu #(.DEPTH_WORDS(128), .WAIT_STATES(3)) u3 (
    .clk(clk), .rst_n(rst3), .req_valid_i(v3), .req_ready_o(rdy3), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_size_i(req_size), .req_wdata_i(req_wdata),
    .rsp_valid_o(rv3), .rsp_rdata_o(rd3), .rsp_err_o(er3));

  // One complete transaction on instance s (0: no wait states, 1: three wait states).
  task automatic xact(input bit s, input bit we, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, input logic [31:0] exp_rd, input bit exp_er);
    int lat;
    logic [32:0] e;
    exp_q.push_back({exp_er, exp_rd});
    @(negedge clk);
    req_we = we; req_addr = a; req_size = sz; req_wdata = wd;
    if (s) v3 = 1; else v0 = 1;
    n_chk++;
    if ((s ? rdy3 : rdy0) !== 1'b1) begin
      n_fail++; $display("FAIL ready_idle addr=%h: got %b expected 1", a, s ? rdy3 : rdy0);
    end
    @(posedge clk);
    @(negedge clk);
    v0 = 0; v3 = 0;
    req_we = $urandom; req_addr = $urandom; req_size = $urandom; req_wdata = $urandom;
    n_chk++;
    if ((s ? rdy3 : rdy0) !== 1'b0) begin
      n_fail++; $display("FAIL ready_busy addr=%h: got %b expected 0", a, s ? rdy3 : rdy0);
    end
    lat = 1;
    while ((s ? rv3 : rv0) !== 1'b1 && lat < 20) begin
      @(negedge clk); lat++;
    end
    n_chk++;
    if (lat != (s ? 4 : 1)) begin
      n_fail++; $display("FAIL latency addr=%h: got %0d expected %0d", a, lat, s ? 4 : 1);
    end
    e = exp_q.pop_front();
    n_chk++;
    if ({(s ? er3 : er0), (s ? rd3 : rd0)} !== e) begin
      n_fail++; $display("FAIL rsp addr=%h size=%b we=%b: got err=%b rdata=%h expected err=%b rdata=%h",
                         a, sz, we, s ? er3 : er0, s ? rd3 : rd0, e[32], e[31:0]);
    end
    @(negedge clk);
    n_chk++;
    if ((s ? rv3 : rv0) !== 1'b0 || {(s ? er3 : er0), (s ? rd3 : rd0)} !== e) begin
      n_fail++; $display("FAIL rsp_hold addr=%h: got valid=%b err=%b rdata=%h expected valid=0 err=%b rdata=%h",
                         a, s ? rv3 : rv0, s ? er3 : er0, s ? rd3 : rd0, e[32], e[31:0]);
    end
  endtask

  task automatic test_reset;
    rst0 = 0; rst3 = 0; v0 = 1; v3 = 1;
    req_we = 1; req_addr = 32'h0; req_size = 3'b010; req_wdata = 32'h0BAD0BAD;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({rdy0, rv0, er0, rd0, rdy3, rv3, er3, rd3} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got rdy0=%b rv0=%b er0=%b rd0=%h rdy3=%b rv3=%b er3=%b rd3=%h expected all 0",
                         rdy0, rv0, er0, rd0, rdy3, rv3, er3, rd3);
    end
    v0 = 0; v3 = 0;
    rst0 = 1; rst3 = 1;
    @(negedge clk);
    n_chk++;
    if ({rdy0, rv0, rdy3, rv3} !== 4'b1010) begin
      n_fail++; $display("FAIL after_reset: got rdy0=%b rv0=%b rdy3=%b rv3=%b expected 1 0 1 0", rdy0, rv0, rdy3, rv3);
    end
  endtask

  task automatic test_load_word;
    xact(0, 0, 32'h10, 3'b010, 0, 32'hAAAAAAAA, 0);
  endtask

  task automatic test_load_ext;
    xact(0, 1, 32'h8, 3'b010, 32'h12345678, 32'h0, 0);
    xact(0, 0, 32'hB, 3'b000, 0, 32'h00000012, 0);
    xact(0, 0, 32'h8, 3'b000, 0, 32'h00000078, 0);
    xact(0, 0, 32'hA, 3'b001, 0, 32'h00001234, 0);
    xact(0, 0, 32'h9, 3'b100, 0, 32'h00000056, 0);
  endtask

  task automatic test_store_lanes;
    xact(0, 1, 32'h5, 3'b000, 32'h000000F0, 32'h0, 0);
    xact(0, 0, 32'h4, 3'b010, 0, 32'hAAAAF0AA, 0);
    xact(0, 0, 32'h5, 3'b000, 0, 32'hFFFFFFF0, 0);
    xact(0, 0, 32'h4, 3'b101, 0, 32'h0000F0AA, 0);
    xact(0, 0, 32'h4, 3'b001, 0, 32'hFFFFF0AA, 0);
    xact(0, 1, 32'h6, 3'b001, 32'hCAFE8001, 32'h0, 0);
    xact(0, 0, 32'h4, 3'b010, 0, 32'h8001F0AA, 0);
    xact(0, 0, 32'h6, 3'b101, 0, 32'h00008001, 0);
  endtask

  task automatic test_errors;
    xact(0, 0, 32'h2,   3'b010, 0, 32'h0, 1);
    xact(0, 1, 32'h3,   3'b001, 32'h0000FFFF, 32'h0, 1);
    xact(0, 0, 32'h0,   3'b010, 0, 32'hAAAAAAAA, 0);
    xact(0, 0, 32'h200, 3'b010, 0, 32'h0, 1);
    xact(0, 0, 32'h10,  3'b011, 0, 32'h0, 1);
    xact(0, 1, 32'h14,  3'b100, 32'h11111111, 32'h0, 1);
    xact(0, 0, 32'h14,  3'b010, 0, 32'hAAAAAAAA, 0);
    xact(0, 1, 32'hE,   3'b010, 32'h22222222, 32'h0, 1);
    xact(0, 0, 32'hC,   3'b010, 0, 32'hAAAAAAAA, 0);
    xact(0, 1, 32'h1FC, 3'b010, 32'h00000055, 32'h0, 0);
    xact(0, 0, 32'h1FC, 3'b010, 0, 32'h00000055, 0);
  endtask

  task automatic test_wait_states;
    xact(1, 0, 32'h10, 3'b010, 0, 32'hAAAAAAAA, 0);
    xact(1, 0, 32'h13, 3'b000, 0, 32'hFFFFFFAA, 0);
  endtask

  task automatic test_back_to_back;
    int acc[$];
    int rvk[$];
    logic [32:0] e;
    exp_q.push_back({1'b0, 32'h0});
    exp_q.push_back({1'b0, 32'h11223344});
    @(negedge clk);
    req_we = 1; req_addr = 32'h20; req_size = 3'b010; req_wdata = 32'h11223344; v3 = 1;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 1) begin req_we = 0; req_wdata = 32'h0; end
      if (k == 6) v3 = 0;
      if (rdy3 && v3) acc.push_back(k);
      if (rv3 === 1'b1) begin
        rvk.push_back(k);
        e = exp_q.pop_front();
        n_chk++;
        if ({er3, rd3} !== e) begin
          n_fail++; $display("FAIL b2b_rsp k=%0d: got err=%b rdata=%h expected err=%b rdata=%h", k, er3, rd3, e[32], e[31:0]);
        end
      end
    end
    n_chk++;
    if (acc.size() != 2 || acc[0] != 0 || acc[1] != 5) begin
      n_fail++; $display("FAIL b2b_accept: got %0d acceptances first=%0d second=%0d expected 2 at 0 and 5",
                         acc.size(), acc.size() > 0 ? acc[0] : -1, acc.size() > 1 ? acc[1] : -1);
    end
    n_chk++;
    if (rvk.size() != 2 || rvk[0] != 4 || rvk[1] != 9) begin
      n_fail++; $display("FAIL b2b_rsp_timing: got %0d strobes first=%0d second=%0d expected 2 at 4 and 9",
                         rvk.size(), rvk.size() > 0 ? rvk[0] : -1, rvk.size() > 1 ? rvk[1] : -1);
    end
    while (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic test_reset_in_wait;
    int seen = 0;
    @(negedge clk);
    req_we = 1; req_addr = 32'h0; req_size = 3'b010; req_wdata = 32'hDEADBEEF; v3 = 1;
    @(posedge clk);
    @(negedge clk);
    v3 = 0;
    @(negedge clk);
    rst3 = 0;
    #1;
    n_chk++;
    if ({rdy3, rv3} !== 2'b00) begin
      n_fail++; $display("FAIL reset_in_wait_during: got rdy3=%b rv3=%b expected 0 0", rdy3, rv3);
    end
    @(negedge clk);
    rst3 = 1;
    @(negedge clk);
    n_chk++;
    if (rdy3 !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_wait_ready: got %b expected 1", rdy3);
    end
    for (int k = 0; k < 6; k++) begin
      if (rv3 === 1'b1) seen++;
      @(negedge clk);
    end
    n_chk++;
    if (seen != 0) begin
      n_fail++; $display("FAIL reset_in_wait_no_rsp: got %0d strobes expected 0", seen);
    end
    xact(1, 0, 32'h0, 3'b010, 0, 32'hAAAAAAAA, 0);
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_load_ext();
    test_store_lanes();
    test_errors();
    test_wait_states();
    test_back_to_back();
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
